// File: rtl/sdram_data_controller.sv
// Single-rank SDRAM controller: power-up init, periodic auto-refresh and one
// auto-precharged single-beat read or write per accepted request.
module sdram_data_controller #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned COL_WIDTH        = 8,
  parameter int unsigned SDRAM_ADDR_WIDTH = 12,
  parameter int unsigned SDRAM_BA_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH       = 22,
  parameter int unsigned CAS_LATENCY      = 2,
  parameter int unsigned INIT_CYCLES      = 100,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RC             = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        data_rd_en,
  input  logic                        data_wr_en,
  input  logic [ADDR_WIDTH-1:0]       data_addr,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic [DATA_WIDTH/8-1:0]     data_byte_en,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic                        bus_busy,
  input  logic [DATA_WIDTH-1:0]       dram_dq_in,
  output logic [DATA_WIDTH-1:0]       dram_dq_out,
  output logic                        dram_dq_oe,
  output logic [SDRAM_ADDR_WIDTH-1:0] dram_addr,
  output logic [SDRAM_BA_WIDTH-1:0]   dram_ba,
  output logic [DATA_WIDTH/8-1:0]     dram_dqm,
  output logic                        dram_cs_n,
  output logic                        dram_ras_n,
  output logic                        dram_cas_n,
  output logic                        dram_we_n,
  output logic                        dram_cke,
  output logic                        dram_clk
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned CntW = 16;

  localparam logic [CntW-1:0] InitCnt  = CntW'(INIT_CYCLES);
  localparam logic [CntW-1:0] RpLast   = CntW'(T_RP - 1);
  localparam logic [CntW-1:0] RcLast   = CntW'(T_RC - 1);
  localparam logic [CntW-1:0] RcdLast  = CntW'(T_RCD - 1);
  localparam logic [CntW-1:0] CapCnt   = CntW'(T_RCD + CAS_LATENCY);
  localparam logic [CntW-1:0] RefiLast = CntW'(REFRESH_INTERVAL - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  localparam logic [SDRAM_ADDR_WIDTH-1:0] A10     = SDRAM_ADDR_WIDTH'(1024);
  localparam logic [SDRAM_ADDR_WIDTH-1:0] MrsWord = SDRAM_ADDR_WIDTH'(CAS_LATENCY << 4);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdMrs = 4'b0000;

  typedef enum logic [3:0] {
    StInitWait, StInitPre, StInitRef1, StInitRef2, StInitMrs, StIdle,
    StActivate, StRcdWait, StRwCmd, StCasWait, StRecover, StRefresh
  } state_e;

  state_e                      state_q;
  logic [CntW-1:0]             cnt_q, ref_cnt_q;
  logic                        ref_en_q, ref_pend_q;
  logic [3:0]                  cmd_q;
  logic [SDRAM_ADDR_WIDTH-1:0] addr_q;
  logic [SDRAM_BA_WIDTH-1:0]   ba_q, bank_q;
  logic [BeW-1:0]              dqm_q, be_q;
  logic [DATA_WIDTH-1:0]       dq_out_q, wdata_q, data_out_q;
  logic                        dq_oe_q, cke_q, data_valid_q, busy_q, is_wr_q;
  logic [COL_WIDTH-1:0]        col_q;

  logic                        ref_expire, accept;
  logic [SDRAM_ADDR_WIDTH-1:0] rw_addr;

  assign ref_expire = ref_en_q && (ref_cnt_q == '0);
  // A request landing on the timer-expiry edge loses to the refresh.
  assign accept     = (state_q == StIdle) && !ref_pend_q && !ref_expire &&
                      (data_rd_en || data_wr_en);
  assign rw_addr    = A10 | SDRAM_ADDR_WIDTH'(col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInitWait;
      cnt_q        <= '0;
      ref_cnt_q    <= '0;
      ref_en_q     <= 1'b0;
      ref_pend_q   <= 1'b0;
      cmd_q        <= 4'b1111;
      addr_q       <= '0;
      ba_q         <= '0;
      bank_q       <= '0;
      dqm_q        <= '1;
      be_q         <= '0;
      dq_out_q     <= '0;
      wdata_q      <= '0;
      data_out_q   <= '0;
      dq_oe_q      <= 1'b0;
      cke_q        <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b1;
      is_wr_q      <= 1'b0;
      col_q        <= '0;
    end else begin
      cke_q        <= 1'b1;
      cmd_q        <= CmdNop;
      dqm_q        <= '1;
      dq_oe_q      <= 1'b0;
      data_valid_q <= 1'b0;
      cnt_q        <= cnt_q + CntOne;
      unique case (state_q)
        StInitWait: if (cnt_q == InitCnt) begin
          cmd_q <= CmdPre; addr_q <= A10; cnt_q <= '0; state_q <= StInitPre;
        end
        StInitPre: if (cnt_q == RpLast) begin
          cmd_q <= CmdRef; cnt_q <= '0; state_q <= StInitRef1;
        end
        StInitRef1: if (cnt_q == RcLast) begin
          cmd_q <= CmdRef; cnt_q <= '0; state_q <= StInitRef2;
        end
        StInitRef2: if (cnt_q == RcLast) begin
          cmd_q <= CmdMrs; addr_q <= MrsWord; ba_q <= '0; cnt_q <= '0;
          state_q <= StInitMrs;
        end
        StInitMrs: if (cnt_q == CntOne) begin
          state_q <= StIdle; busy_q <= 1'b0;
        end
        StIdle: begin
          if (ref_pend_q) begin
            cmd_q <= CmdRef; cnt_q <= '0; state_q <= StRefresh; busy_q <= 1'b1;
          end else if (accept) begin
            cmd_q   <= CmdAct;
            addr_q  <= data_addr[COL_WIDTH +: SDRAM_ADDR_WIDTH];
            ba_q    <= data_addr[ADDR_WIDTH-1 -: SDRAM_BA_WIDTH];
            bank_q  <= data_addr[ADDR_WIDTH-1 -: SDRAM_BA_WIDTH];
            col_q   <= data_addr[COL_WIDTH-1:0];
            wdata_q <= data_in;
            be_q    <= data_byte_en;
            is_wr_q <= data_wr_en;
            cnt_q   <= '0;
            state_q <= StActivate;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= ref_expire;
          end
        end
        StActivate, StRcdWait: begin
          if (cnt_q == RcdLast) begin
            cmd_q   <= is_wr_q ? CmdWr : CmdRd;
            addr_q  <= rw_addr;
            ba_q    <= bank_q;
            state_q <= StRwCmd;
            if (is_wr_q) begin
              dq_oe_q <= 1'b1; dq_out_q <= wdata_q; dqm_q <= ~be_q;
            end else begin
              dqm_q <= '0;
            end
          end else begin
            state_q <= StRcdWait;
          end
        end
        StRwCmd: begin
          if (is_wr_q) begin
            state_q <= StRecover;
          end else begin
            dqm_q <= '0; state_q <= StCasWait;
          end
        end
        StCasWait: begin
          if (cnt_q == CapCnt) begin
            data_out_q <= dram_dq_in; data_valid_q <= 1'b1;
            if (cnt_q >= RcLast) begin
              state_q <= StIdle; busy_q <= ref_pend_q || ref_expire;
            end else begin
              state_q <= StRecover;
            end
          end else begin
            dqm_q <= '0;
          end
        end
        StRecover: if (cnt_q >= RcLast) begin
          state_q <= StIdle; busy_q <= ref_pend_q || ref_expire;
        end
        StRefresh: if (cnt_q == RcLast) begin
          state_q <= StIdle; busy_q <= ref_expire; ref_pend_q <= 1'b0;
        end
        default: state_q <= StInitWait;
      endcase

      // Free-running refresh timer; an expiry always wins over the pending clear.
      if (state_q == StInitMrs && cnt_q == CntOne) begin
        ref_en_q  <= 1'b1;
        ref_cnt_q <= RefiLast;
      end else if (ref_en_q) begin
        if (ref_expire) begin
          ref_cnt_q  <= RefiLast;
          ref_pend_q <= 1'b1;
        end else begin
          ref_cnt_q <= ref_cnt_q - CntOne;
        end
      end
    end
  end

  assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;
  assign dram_addr   = addr_q;
  assign dram_ba     = ba_q;
  assign dram_dqm    = dqm_q;
  assign dram_dq_out = dq_out_q;
  assign dram_dq_oe  = dq_oe_q;
  assign dram_cke    = cke_q;
  assign dram_clk    = ~clk;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign bus_busy    = busy_q;

endmodule

// File: tb/tb_sdram_data_controller.sv
// Directed bench for sdram_data_controller with a behavioural single-beat
// SDRAM model driving dram_dq_in.
module tb_sdram_data_controller;

  localparam int CL = 2;
  localparam logic [3:0] Nop = 4'b0111, Act = 4'b0011, Rd = 4'b0101, Wr = 4'b0100;
  localparam logic [3:0] Pre = 4'b0010, Ref = 4'b0001, Mrs = 4'b0000;
  localparam logic [31:0] Junk = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_rd_en, data_wr_en;
  logic [21:0] data_addr;
  logic [31:0] data_in, data_out, dram_dq_in, dram_dq_out;
  logic [3:0]  data_byte_en, dram_dqm;
  logic        data_valid, bus_busy, dram_dq_oe;
  logic [11:0] dram_addr;
  logic [1:0]  dram_ba;
  logic        dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_cke, dram_clk;

  sdram_data_controller dut (
    .clk(clk), .rst_n(rst_n),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr),
    .data_in(data_in), .data_byte_en(data_byte_en), .data_out(data_out),
    .data_valid(data_valid), .bus_busy(bus_busy),
    .dram_dq_in(dram_dq_in), .dram_dq_out(dram_dq_out), .dram_dq_oe(dram_dq_oe),
    .dram_addr(dram_addr), .dram_ba(dram_ba), .dram_dqm(dram_dqm),
    .dram_cs_n(dram_cs_n), .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n),
    .dram_we_n(dram_we_n), .dram_cke(dram_cke), .dram_clk(dram_clk)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- SDRAM model (samples commands mid-cycle) ----------------
  logic [3:0]  cmd;
  assign cmd = {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n};

  logic [11:0] row_act [4];
  logic [31:0] mem [int unsigned];
  int          n_act, n_rd, n_wr, n_ref, n_valid;
  int          first_cmd_cyc, ref1_cyc, ref2_cyc, mrs_cyc, last_ref_cyc, last_rd_cyc;
  logic [3:0]  first_cmd, wr_dqm;
  logic [11:0] pre_addr, mrs_addr;
  logic [1:0]  mrs_ba;
  logic        rd_a10, wr_a10, wr_oe;
  logic [31:0] wr_data, rd_data;
  int          rd_cnt;

  task automatic model_step();
    int unsigned key;
    logic [31:0] w;
    if (rd_cnt > 0) begin
      rd_cnt--;
      dram_dq_in = (rd_cnt == 0) ? rd_data : Junk;
    end else begin
      dram_dq_in = Junk;
    end
    if (!rst_n) begin
      n_act = 0; n_rd = 0; n_wr = 0; n_ref = 0; n_valid = 0; rd_cnt = 0;
      first_cmd_cyc = -1; ref1_cyc = -1; ref2_cyc = -1; mrs_cyc = -1;
    end else begin
      if (first_cmd_cyc < 0 && cmd != Nop) begin
        first_cmd_cyc = cyc; first_cmd = cmd; pre_addr = dram_addr;
      end
      key = 32'({dram_ba, row_act[dram_ba], dram_addr[7:0]});
      case (cmd)
        Act: begin row_act[dram_ba] = dram_addr; n_act++; end
        Rd: begin
          rd_data = mem.exists(key) ? mem[key] : 32'h0;
          rd_cnt = CL; rd_a10 = dram_addr[10]; last_rd_cyc = cyc; n_rd++;
        end
        Wr: begin
          w = mem.exists(key) ? mem[key] : 32'h0;
          for (int b = 0; b < 4; b++) if (!dram_dqm[b]) w[8*b +: 8] = dram_dq_out[8*b +: 8];
          mem[key] = w;
          wr_dqm = dram_dqm; wr_oe = dram_dq_oe; wr_data = dram_dq_out;
          wr_a10 = dram_addr[10]; n_wr++;
        end
        Ref: begin
          if (n_ref == 0) ref1_cyc = cyc;
          else if (n_ref == 1) ref2_cyc = cyc;
          last_ref_cyc = cyc; n_ref++;
        end
        Mrs: begin mrs_cyc = cyc; mrs_addr = dram_addr; mrs_ba = dram_ba; end
        default: ;
      endcase
      if (data_valid) n_valid++;
    end
  endtask

  initial begin
    dram_dq_in = Junk;
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (bus_busy && t < 300) begin step(); t++; end
    check({name, "_ready"}, 32'(bus_busy), 32'd0);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [21:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    data_rd_en = rd; data_wr_en = wr; data_addr = a; data_in = d; data_byte_en = be;
    @(posedge clk);
    #1;
    data_rd_en = 1'b0; data_wr_en = 1'b0;
  endtask

  task automatic check_reset(input string name);
    check({name, "_busy"},  32'(bus_busy), 32'd1);
    check({name, "_cke"},   32'(dram_cke), 32'd0);
    check({name, "_cmd"},   32'(cmd), 32'hF);
    check({name, "_dqm"},   32'(dram_dqm), 32'hF);
    check({name, "_oe"},    32'(dram_dq_oe), 32'd0);
    check({name, "_addr"},  32'(dram_addr), 32'd0);
    check({name, "_dout"},  data_out, 32'd0);
    check({name, "_valid"}, 32'(data_valid), 32'd0);
  endtask

  // Called just after rst_n is released; expects PRE@101, REF@103/110, MRS@117, idle@119.
  task automatic do_init(input string name);
    int t = 0;
    step();
    check({name, "_cke"}, 32'(dram_cke), 32'd1);
    check({name, "_busy0"}, 32'(bus_busy), 32'd1);
    while (bus_busy && t < 400) begin step(); t++; end
    check({name, "_idle_cyc"}, 32'(cyc), 32'd119);
    check({name, "_first_cmd"}, 32'(first_cmd), 32'(Pre));
    check({name, "_pre_cyc"}, 32'(first_cmd_cyc), 32'd101);
    check({name, "_pre_a10"}, 32'(pre_addr[10]), 32'd1);
    check({name, "_ref1_cyc"}, 32'(ref1_cyc), 32'd103);
    check({name, "_ref2_cyc"}, 32'(ref2_cyc), 32'd110);
    check({name, "_mrs_cyc"}, 32'(mrs_cyc), 32'd117);
    check({name, "_mrs_addr"}, 32'(mrs_addr), 32'h020);
    check({name, "_mrs_ba"}, 32'(mrs_ba), 32'd0);
    check({name, "_n_ref"}, 32'(n_ref), 32'd2);
    check({name, "_no_valid"}, 32'(n_valid), 32'd0);
  endtask

  task automatic do_write(input string name, input logic [21:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    int w0, t;
    logic [3:0] nbe;
    nbe = ~be;
    wait_ready(name);
    w0 = n_wr;
    issue(1'b0, 1'b1, a, d, be);
    t = 0;
    while (n_wr == w0 && t < 20) begin step(); t++; end
    check({name, "_issued"}, 32'(n_wr), 32'(w0 + 1));
    check({name, "_dqm"}, 32'(wr_dqm), 32'(nbe));
    check({name, "_oe"}, 32'(wr_oe), 32'd1);
    check({name, "_dq"}, wr_data, d);
    check({name, "_a10"}, 32'(wr_a10), 32'd1);
    step();
    check({name, "_oe_off"}, 32'(dram_dq_oe), 32'd0);
  endtask

  task automatic do_read(input string name, input logic [21:0] a, input logic [31:0] exp);
    int t = 0;
    wait_ready(name);
    issue(1'b1, 1'b0, a, 32'h0, 4'h0);
    while (!data_valid && t < 40) begin step(); t++; end
    check({name, "_valid"}, 32'(data_valid), 32'd1);
    check({name, "_data"}, data_out, exp);
    check({name, "_latency"}, 32'(cyc - last_rd_cyc), 32'(CL + 1));
    check({name, "_a10"}, 32'(rd_a10), 32'd1);
    step();
    check({name, "_pulse"}, 32'(data_valid), 32'd0);
    check({name, "_hold"}, data_out, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [21:0] addr;
    logic [31:0] data;  // write data, or expected read data
    logic [3:0]  be;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int r0, w0, v0, a0, f0, b, t;
    vecs[0]  = '{1'b1, 22'd788,     32'hABCD_EF98, 4'hF};
    vecs[1]  = '{1'b0, 22'd788,     32'hABCD_EF98, 4'h0};
    vecs[2]  = '{1'b1, 22'd1985,    32'hFFFF_FFFF, 4'hF};
    vecs[3]  = '{1'b1, 22'd1985,    32'h0123_4567, 4'h5};
    vecs[4]  = '{1'b0, 22'd1985,    32'hFF23_FF67, 4'h0};
    vecs[5]  = '{1'b1, 22'h3F_FFFF, 32'h1234_5678, 4'hF};
    vecs[6]  = '{1'b1, 22'h3F_FFFF, 32'hAAAA_AAAA, 4'h8};
    vecs[7]  = '{1'b0, 22'h3F_FFFF, 32'hAA34_5678, 4'h0};
    vecs[8]  = '{1'b1, 22'h00_0414, 32'h0BAD_F00D, 4'hF};
    vecs[9]  = '{1'b0, 22'h00_0414, 32'h0BAD_F00D, 4'h0};
    vecs[10] = '{1'b0, 22'd788,     32'hABCD_EF98, 4'h0};
    vecs[11] = '{1'b1, 22'h20_0014, 32'hCAFE_BABE, 4'h3};
    vecs[12] = '{1'b0, 22'h20_0014, 32'h0000_BABE, 4'h0};
    vecs[13] = '{1'b0, 22'h00_0014, 32'h0000_0000, 4'h0};
    vecs[14] = '{1'b0, 22'd1985,    32'hFF23_FF67, 4'h0};

    data_rd_en = 1'b0; data_wr_en = 1'b0; data_addr = '0; data_in = '0; data_byte_en = '0;
    repeat (3) step();
    check_reset("por");
    rst_n = 1'b1;
    do_init("init");

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].be);
      else            do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
    end

    // Read request held while busy must be dropped, not queued.
    wait_ready("drop");
    r0 = n_rd; w0 = n_wr;
    issue(1'b0, 1'b1, 22'd50, 32'h77, 4'hF);
    data_rd_en = 1'b1;
    check("drop_busy", 32'(bus_busy), 32'd1);
    repeat (3) step();
    data_rd_en = 1'b0;
    wait_ready("drop_end");
    check("drop_no_read", 32'(n_rd), 32'(r0));
    check("drop_write", 32'(n_wr), 32'(w0 + 1));

    // Simultaneous read+write: only the write runs, data_out keeps the last read.
    wait_ready("both");
    r0 = n_rd; w0 = n_wr; v0 = n_valid;
    issue(1'b1, 1'b1, 22'd100, 32'h5555_AAAA, 4'hF);
    repeat (2) step();
    wait_ready("both_end");
    repeat (4) step();
    check("both_write", 32'(n_wr), 32'(w0 + 1));
    check("both_no_read", 32'(n_rd), 32'(r0));
    check("both_no_valid", 32'(n_valid), 32'(v0));
    check("both_hold", data_out, 32'hFF23_FF67);
    do_read("both_rb", 22'd100, 32'h5555_AAAA);

    // Request on the first timer-expiry edge (end of cycle 898) loses to REF.
    t = 0;
    while (cyc < 898 && t < 2000) begin step(); t++; end
    check("coll_cyc", 32'(cyc), 32'd898);
    check("coll_idle", 32'(bus_busy), 32'd0);
    r0 = n_rd; a0 = n_act; f0 = n_ref; v0 = n_valid;
    issue(1'b1, 1'b0, 22'd788, 32'h0, 4'h0);
    step();
    b = 0;
    for (int k = 0; k < 30; k++) begin
      if (!bus_busy) break;
      b++;
      step();
    end
    check("coll_busy_len", 32'(b), 32'd8);
    check("coll_ref_cyc", 32'(last_ref_cyc), 32'd900);
    check("coll_ref", 32'(n_ref), 32'(f0 + 1));
    check("coll_no_act", 32'(n_act), 32'(a0));
    check("coll_no_read", 32'(n_rd), 32'(r0));
    check("coll_no_valid", 32'(n_valid), 32'(v0));

    // Reset in the middle of a read aborts it and restarts the init sequence.
    wait_ready("rst");
    r0 = n_rd;
    issue(1'b1, 1'b0, 22'd788, 32'h0, 4'h0);
    t = 0;
    while (n_rd == r0 && t < 20) begin step(); t++; end
    check("rst_read_issued", 32'(n_rd), 32'(r0 + 1));
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (3) step();
    rst_n = 1'b1;
    do_init("reinit");
    do_read("post_rst", 22'd788, 32'hABCD_EF98);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
